// File: rtl/insn_decoder_pkg.sv
// ============================================================================
// Package  : insn_decoder_pkg
// Brief    : Shared instruction-set definitions: widths, field positions,
//            opcodes, forwarding encoding and decoder state types.
// Revision : 1.0
// ============================================================================
`default_nettype none

package insn_decoder_pkg;

   localparam int LEN_INSN      = 32;
   localparam int MEM_INSN_ADDR = 10;
   localparam int LEN_OPCODE    = 6;
   localparam int LEN_REG_ADDR  = 5;
   localparam int LEN_IMM       = 16;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RD_MSB  = 25;
   localparam int RD_LSB  = 21;
   localparam int RS_MSB  = 20;
   localparam int RS_LSB  = 16;
   localparam int RT_MSB  = 15;
   localparam int RT_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam logic [LEN_OPCODE-1:0] OP_NOP  = 6'd0;
   localparam logic [LEN_OPCODE-1:0] OP_ADD  = 6'd1;
   localparam logic [LEN_OPCODE-1:0] OP_SUB  = 6'd2;
   localparam logic [LEN_OPCODE-1:0] OP_ADDI = 6'd3;
   localparam logic [LEN_OPCODE-1:0] OP_LD   = 6'd4;
   localparam logic [LEN_OPCODE-1:0] OP_ST   = 6'd5;
   localparam logic [LEN_OPCODE-1:0] OP_BEQ  = 6'd6;
   localparam logic [LEN_OPCODE-1:0] OP_HALT = 6'd7;

   typedef enum logic [1:0] {
      FWD_REGFILE = 2'd0,
      FWD_PREV    = 2'd1,
      FWD_PREV2   = 2'd2
   } fwd_e;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   typedef struct packed {
      logic                    we;
      logic [LEN_REG_ADDR-1:0] rd;
   } hist_t;

   // The most recent writer takes priority over the older one.
   function automatic logic [1:0] fwd_select(input hist_t h0, input hist_t h1,
                                             input logic [LEN_REG_ADDR-1:0] r);
      if (h0.we && (h0.rd == r))
         return FWD_PREV;
      else if (h1.we && (h1.rd == r))
         return FWD_PREV2;
      else
         return FWD_REGFILE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/insn_field_decode.sv
// ============================================================================
// Module   : insn_field_decode
// Brief    : Combinational opcode table producing write-enable, illegal and
//            halt flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module insn_field_decode
   import insn_decoder_pkg::*;
(
   input  logic [LEN_OPCODE-1:0]   opcode,
   input  logic [LEN_REG_ADDR-1:0] rd,
   output logic                    we,
   output logic                    illegal,
   output logic                    is_halt
);

   always_comb begin
      we      = 1'b0;
      illegal = 1'b0;
      is_halt = 1'b0;
      case (opcode)
         // r0 is hardwired, so writing it is suppressed here
         OP_ADD, OP_SUB, OP_ADDI, OP_LD: we = (rd != '0);
         OP_NOP, OP_ST, OP_BEQ:          we = 1'b0;
         OP_HALT:                        is_halt = 1'b1;
         default:                        illegal = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/insn_decoder.sv
// ============================================================================
// Module   : insn_decoder
// Brief    : Decode stage: registers instruction fields, flags illegal
//            opcodes, computes operand forwarding selects, stops on HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module insn_decoder
   import insn_decoder_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [LEN_INSN-1:0]      insn,
   output logic                     dec_valid,
   output logic [MEM_INSN_ADDR-1:0] dec_pc,
   output logic [LEN_OPCODE-1:0]    dec_opcode,
   output logic [LEN_REG_ADDR-1:0]  dec_rd,
   output logic [LEN_REG_ADDR-1:0]  dec_rs,
   output logic [LEN_REG_ADDR-1:0]  dec_rt,
   output logic [LEN_INSN-1:0]      dec_imm,
   output logic                     dec_we,
   output logic                     dec_illegal,
   output logic [1:0]               fwd_rs,
   output logic [1:0]               fwd_rt,
   output logic                     halted
);

   localparam logic [MEM_INSN_ADDR-1:0] c_pc_one = {{(MEM_INSN_ADDR-1){1'b0}}, 1'b1};

   logic [LEN_OPCODE-1:0]   w_opcode;
   logic [LEN_REG_ADDR-1:0] w_rd;
   logic [LEN_REG_ADDR-1:0] w_rs;
   logic [LEN_REG_ADDR-1:0] w_rt;
   logic [LEN_INSN-1:0]     w_imm;
   logic                    w_we;
   logic                    w_illegal;
   logic                    w_is_halt;

   assign w_opcode = insn[OPC_MSB:OPC_LSB];
   assign w_rd     = insn[RD_MSB:RD_LSB];
   assign w_rs     = insn[RS_MSB:RS_LSB];
   assign w_rt     = insn[RT_MSB:RT_LSB];
   assign w_imm    = {{(LEN_INSN-LEN_IMM){insn[IMM_MSB]}}, insn[IMM_MSB:IMM_LSB]};

   insn_field_decode u_field_decode (
      .opcode  (w_opcode),
      .rd      (w_rd),
      .we      (w_we),
      .illegal (w_illegal),
      .is_halt (w_is_halt)
   );

   state_e                   r_state;
   logic [MEM_INSN_ADDR-1:0] r_next_pc;
   hist_t                    r_hist0;
   hist_t                    r_hist1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_WARMUP;
         r_next_pc   <= '0;
         r_hist0     <= '0;
         r_hist1     <= '0;
         dec_valid   <= 1'b0;
         dec_pc      <= '0;
         dec_opcode  <= '0;
         dec_rd      <= '0;
         dec_rs      <= '0;
         dec_rt      <= '0;
         dec_imm     <= '0;
         dec_we      <= 1'b0;
         dec_illegal <= 1'b0;
         fwd_rs      <= '0;
         fwd_rt      <= '0;
         halted      <= 1'b0;
      end else begin
         case (r_state)
            // Instruction memory has not produced mem[0] yet
            ST_WARMUP: r_state <= ST_RUN;
            ST_RUN: begin
               dec_valid   <= 1'b1;
               dec_pc      <= r_next_pc;
               r_next_pc   <= r_next_pc + c_pc_one;
               dec_opcode  <= w_opcode;
               dec_rd      <= w_rd;
               dec_rs      <= w_rs;
               dec_rt      <= w_rt;
               dec_imm     <= w_imm;
               dec_we      <= w_we;
               dec_illegal <= w_illegal;
               // Selects use history from before this instruction's shift
               fwd_rs      <= fwd_select(r_hist0, r_hist1, w_rs);
               fwd_rt      <= fwd_select(r_hist0, r_hist1, w_rt);
               r_hist0     <= '{we: w_we, rd: w_rd};
               r_hist1     <= r_hist0;
               if (w_is_halt) begin
                  halted  <= 1'b1;
                  r_state <= ST_HALTED;
               end
            end
            ST_HALTED: dec_valid <= 1'b0;
            default:   r_state <= ST_WARMUP;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_insn_decoder.sv
// ============================================================================
// Module   : tb_insn_decoder
// Brief    : Directed, table-driven bench for insn_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_insn_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] insn = '0;
   logic        dec_valid;
   logic [9:0]  dec_pc;
   logic [5:0]  dec_opcode;
   logic [4:0]  dec_rd, dec_rs, dec_rt;
   logic [31:0] dec_imm;
   logic        dec_we, dec_illegal;
   logic [1:0]  fwd_rs, fwd_rt;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   insn_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .insn        (insn),
      .dec_valid   (dec_valid),
      .dec_pc      (dec_pc),
      .dec_opcode  (dec_opcode),
      .dec_rd      (dec_rd),
      .dec_rs      (dec_rs),
      .dec_rt      (dec_rt),
      .dec_imm     (dec_imm),
      .dec_we      (dec_we),
      .dec_illegal (dec_illegal),
      .fwd_rs      (fwd_rs),
      .fwd_rt      (fwd_rt),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] insn;
      logic [5:0]  op;
      logic [4:0]  rd, rs, rt;
      logic [31:0] imm;
      logic        we, ill;
      logic [1:0]  frs, frt;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
      return {op, rd, rs, rt, 11'd0};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic add(input logic [31:0] w, input logic [5:0] op, input logic [4:0] rd,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm,
                      input logic we, input logic ill, input logic [1:0] frs,
                      input logic [1:0] frt);
      vec_t v;
      v.insn = w; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm;
      v.we = we; v.ill = ill; v.frs = frs; v.frt = frt;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [31:0] w);
      insn = w;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".valid"},  32'(dec_valid),   32'd0);
      chk({tag, ".halted"}, 32'(halted),      32'd0);
      chk({tag, ".pc"},     32'(dec_pc),      32'd0);
      chk({tag, ".op"},     32'(dec_opcode),  32'd0);
      chk({tag, ".regs"},   32'({dec_rd, dec_rs, dec_rt}), 32'd0);
      chk({tag, ".imm"},    dec_imm,          32'd0);
      chk({tag, ".flags"},  32'({dec_we, dec_illegal}), 32'd0);
      chk({tag, ".fwd"},    32'({fwd_rs, fwd_rt}), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within its time budget");
      $fatal(1);
   end

   initial begin
      // pc-indexed program; expected values worked out by hand
      add(mk_r(6'd1, 5'd1, 5'd2, 5'd3),    6'd1, 5'd1, 5'd2, 5'd3,   32'h00001800, 1, 0, 2'd0, 2'd0);
      add(mk_i(6'd3, 5'd4, 5'd0, 16'hFFFB),6'd3, 5'd4, 5'd0, 5'd31,  32'hFFFFFFFB, 1, 0, 2'd0, 2'd0);
      add(mk_r(6'd1, 5'd5, 5'd1, 5'd4),    6'd1, 5'd5, 5'd1, 5'd4,   32'h00002000, 1, 0, 2'd2, 2'd1);
      add(32'h0,                            6'd0, 5'd0, 5'd0, 5'd0,   32'h00000000, 0, 0, 2'd0, 2'd0);
      add(mk_r(6'd2, 5'd6, 5'd5, 5'd5),    6'd2, 5'd6, 5'd5, 5'd5,   32'h00002800, 1, 0, 2'd2, 2'd2);
      add(mk_r(6'd1, 5'd5, 5'd1, 5'd1),    6'd1, 5'd5, 5'd1, 5'd1,   32'h00000800, 1, 0, 2'd0, 2'd0);
      add(mk_r(6'd2, 5'd7, 5'd5, 5'd0),    6'd2, 5'd7, 5'd5, 5'd0,   32'h00000000, 1, 0, 2'd1, 2'd0);
      add(mk_r(6'd1, 5'd0, 5'd2, 5'd2),    6'd1, 5'd0, 5'd2, 5'd2,   32'h00001000, 0, 0, 2'd0, 2'd0);
      add(mk_r(6'd1, 5'd8, 5'd0, 5'd0),    6'd1, 5'd8, 5'd0, 5'd0,   32'h00000000, 1, 0, 2'd0, 2'd0);
      add(mk_r(6'd9, 5'd9, 5'd8, 5'd7),    6'd9, 5'd9, 5'd8, 5'd7,   32'h00003800, 0, 1, 2'd1, 2'd0);
      add(mk_r(6'd1, 5'd9, 5'd8, 5'd9),    6'd1, 5'd9, 5'd8, 5'd9,   32'h00004800, 1, 0, 2'd2, 2'd0);
      add(mk_i(6'd4, 5'd10, 5'd9, 16'h8000),6'd4, 5'd10, 5'd9, 5'd16, 32'hFFFF8000, 1, 0, 2'd1, 2'd0);
      add(mk_i(6'd5, 5'd10, 5'd10, 16'h0004),6'd5, 5'd10, 5'd10, 5'd0, 32'h00000004, 0, 0, 2'd1, 2'd0);
      add(mk_i(6'd6, 5'd3, 5'd10, 16'hFFFE),6'd6, 5'd3, 5'd10, 5'd31, 32'hFFFFFFFE, 0, 0, 2'd2, 2'd0);
      add(mk_r(6'd1, 5'd11, 5'd0, 5'd0),   6'd1, 5'd11, 5'd0, 5'd0,  32'h00000000, 1, 0, 2'd0, 2'd0);
      add(mk_r(6'd1, 5'd11, 5'd0, 5'd0),   6'd1, 5'd11, 5'd0, 5'd0,  32'h00000000, 1, 0, 2'd0, 2'd0);
      add(mk_r(6'd2, 5'd12, 5'd11, 5'd11), 6'd2, 5'd12, 5'd11, 5'd11, 32'h00005800, 1, 0, 2'd1, 2'd1);

      // Reset state while reset is held across an edge
      @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst = 1'b0;

      step(32'hDEADBEEF);
      chk("warmup.valid", 32'(dec_valid), 32'd0);
      chk("warmup.op",    32'(dec_opcode), 32'd0);

      foreach (vq[i]) begin
         step(vq[i].insn);
         chk($sformatf("v%0d.valid", i),   32'(dec_valid),   32'd1);
         chk($sformatf("v%0d.pc", i),      32'(dec_pc),      32'(i));
         chk($sformatf("v%0d.op", i),      32'(dec_opcode),  32'(vq[i].op));
         chk($sformatf("v%0d.rd", i),      32'(dec_rd),      32'(vq[i].rd));
         chk($sformatf("v%0d.rs", i),      32'(dec_rs),      32'(vq[i].rs));
         chk($sformatf("v%0d.rt", i),      32'(dec_rt),      32'(vq[i].rt));
         chk($sformatf("v%0d.imm", i),     dec_imm,          vq[i].imm);
         chk($sformatf("v%0d.we", i),      32'(dec_we),      32'(vq[i].we));
         chk($sformatf("v%0d.illegal", i), 32'(dec_illegal), 32'(vq[i].ill));
         chk($sformatf("v%0d.fwd_rs", i),  32'(fwd_rs),      32'(vq[i].frs));
         chk($sformatf("v%0d.fwd_rt", i),  32'(fwd_rt),      32'(vq[i].frt));
         chk($sformatf("v%0d.halted", i),  32'(halted),      32'd0);
      end

      // HALT at address 3, then freeze, then asynchronous reset while halted
      do_reset();
      step(32'h0);
      step(32'h0);
      step(32'h0);
      step(32'h0);
      step(mk_r(6'd7, 5'd2, 5'd3, 5'd4));
      chk("halt.valid",  32'(dec_valid),  32'd1);
      chk("halt.pc",     32'(dec_pc),     32'd3);
      chk("halt.halted", 32'(halted),     32'd1);
      chk("halt.op",     32'(dec_opcode), 32'd7);
      chk("halt.we",     32'(dec_we),     32'd0);
      chk("halt.ill",    32'(dec_illegal), 32'd0);
      for (int k = 0; k < 2; k++) begin
         step(mk_r(6'd1, 5'd1, 5'd1, 5'd1));
         chk($sformatf("halted%0d.valid", k),  32'(dec_valid),  32'd0);
         chk($sformatf("halted%0d.halted", k), 32'(halted),     32'd1);
         chk($sformatf("halted%0d.pc", k),     32'(dec_pc),     32'd3);
         chk($sformatf("halted%0d.op", k),     32'(dec_opcode), 32'd7);
         chk($sformatf("halted%0d.rd", k),     32'(dec_rd),     32'd2);
      end
      rst = 1'b1;
      #2;
      chk_reset_state("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(mk_r(6'd1, 5'd1, 5'd2, 5'd3));
      chk("restart.warmup_valid", 32'(dec_valid), 32'd0);
      step(mk_r(6'd1, 5'd1, 5'd2, 5'd3));
      chk("restart.valid",  32'(dec_valid),  32'd1);
      chk("restart.pc",     32'(dec_pc),     32'd0);
      chk("restart.op",     32'(dec_opcode), 32'd1);
      chk("restart.halted", 32'(halted),     32'd0);

      // PC wrap across 2^10 addresses
      do_reset();
      step(32'h0);
      for (int n = 0; n < 1026; n++) begin
         step(32'h0);
         chk($sformatf("wrap%0d.valid", n), 32'(dec_valid), 32'd1);
         chk($sformatf("wrap%0d.pc", n),    32'(dec_pc),    32'(n % 1024));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/insn_decoder.md
# insn_decoder

Decode stage directly downstream of the instruction fetcher. Consumes the fetcher's free-running instruction word (one per cycle, no stall path) and handles the one-cycle memory read latency after reset. Splits each instruction into registered fields, flags illegal opcodes and computes operand forwarding selects from a two-deep write history for the execute stage. Stops issuing on HALT until the next reset.

## Interface
- LEN_INSN, 32, instruction width (from defs_insn.v)
- MEM_INSN_ADDR, 10, instruction address width; PC width (from defs_insn.v)
- LEN_OPCODE, 6, opcode width; field insn[31:26]
- LEN_REG_ADDR, 5, register index width; rd insn[25:21], rs insn[20:16], rt insn[15:11]
- LEN_IMM, 16, immediate width; field insn[15:0]

- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- insn  in  LEN_INSN  instruction word from fetcher
- dec_valid  out  1  decoded fields are a live instruction
- dec_pc  out  MEM_INSN_ADDR  address of decoded instruction
- dec_opcode  out  LEN_OPCODE  opcode
- dec_rd / dec_rs / dec_rt  out  LEN_REG_ADDR each  register indices
- dec_imm  out  LEN_INSN  sign-extended immediate
- dec_we  out  1  instruction writes rd
- dec_illegal  out  1  opcode not in table
- fwd_rs / fwd_rt  out  2 each  operand source: 0 regfile, 1 previous insn, 2 insn two back
- halted  out  1  HALT decoded

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 ADDI, 4 LD, 5 ST, 6 BEQ, 7 HALT; 8..63 illegal.
- dec_we = 1 for ADD, SUB, ADDI, LD, and only when rd != 0; else 0. Illegal: dec_we=0, dec_illegal=1, dec_valid=1.
- dec_imm = {{16{insn[15]}}, insn[15:0]}, computed for every opcode.
- States: WARMUP -> RUN -> HALTED.
  - WARMUP: entered on reset; one cycle; insn not yet valid, nothing latched; -> RUN.
  - RUN: each edge latches insn into the output registers, dec_valid=1, dec_pc increments (starts at 0, wraps 2^MEM_INSN_ADDR-1 -> 0 silently).
  - HALT latched in RUN: dec_valid=1 for HALT itself, halted=1 on the same edge, -> HALTED.
  - HALTED: dec_valid=0, fields hold, history unchanged; exit only via reset.
- Forwarding history: two entries (we, rd), shifted on every dec_valid edge. fwd_rs=1 if hist0.we and hist0.rd==rs; else 2 if hist1.we and hist1.rd==rs; else 0. Same for rt. rd==0 never forwards (we already 0). Previous wins when both match.
- fwd_* computed from history before the current instruction's shift, registered with the fields.

## Timing
- Reset (async assert): dec_valid=0, halted=0, dec_pc=0, all fields 0, fwd_*=0, history cleared, state WARMUP.
- Edge 1 after deassert: WARMUP -> RUN, outputs unchanged (memory returns mem[0]).
- Edge 2: insn from address 0 latched; dec_valid=1, dec_pc=0. Latency fetch-address -> decoded output: 2 edges.
- Thereafter one instruction per cycle; no backpressure, no bubbles.
- Reset mid-run: all outputs to reset values immediately; resumes with WARMUP.

## Structure
- Opcode values, field bit positions and the fwd encoding (0/1/2) go in defs_insn.v, shared with fetcher and execute.
- One sub-module natural: insn_field_decode (combinational opcode table -> we, illegal, is_halt); sequencing, history and registers stay in insn_decoder.

## Test plan
- Reset then ADD r1,r2,r3 at addr 0: dec_valid 0 after edge 1, 1 after edge 2 with dec_pc=0, opcode=1, rd=1, rs=2, rt=3, dec_we=1.
- ADDI r4,r0,-5 (imm 0xFFFB): dec_imm=0xFFFFFFFB, dec_we=1.
- ADD r5,.. ; NOP ; SUB r6,r5,r5 -> SUB has fwd_rs=fwd_rt=2; ADD r5 then SUB r7,r5,r0 -> fwd_rs=1, fwd_rt=0; ADD r0,.. then use r0 -> fwd=0.
- Opcode 9 -> dec_illegal=1, dec_we=0, dec_valid=1; next insn decodes normally.
- HALT at addr 3: dec_valid=1 with pc=3, halted=1; following cycles dec_valid=0, fields frozen; reset mid-HALTED -> halted=0, restart from pc 0.
- Run 2^MEM_INSN_ADDR+2 NOPs: dec_pc wraps to 0, dec_valid stays 1.
